// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : seq_pkg
// Description : Shared types and constants for the serial sequence
//               generator/detector family.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_pkg;

  // Transmitter states; GAP is only reachable when SEQ_TX_GAP_EN is defined.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 4;
  localparam int REPS_W_DEF = 4;

  // Reference pattern searched for by the 1011 detectors.
  localparam logic [3:0] PATTERN_1011 = 4'b1011;

endpackage
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : seq_pattern_tx
// Description : Serial pattern transmitter. Accepts a pattern and a repeat
//               count over valid/ready, then sends the pattern MSB-first,
//               one bit per clock, (in_reps + 1) times.
// Options     : SEQ_TX_GAP_EN - insert one invalid GAP cycle after every
//               frame (including the last) so frame boundaries are visible.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REPS_W = REPS_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [REPS_W-1:0] in_reps,
  output logic              x,
  output logic              x_valid,
  output logic              frame_start,
  output logic              busy,
  output logic              done
);

  localparam int                BCNT_W   = $clog2(DATA_W);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   pat_q, pat_d;     // pattern captured at handshake
  logic [DATA_W-1:0]   sreg_q, sreg_d;   // MSB is the bit currently on x
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;   // bits left in frame after current
  logic [REPS_W-1:0]   fcnt_q, fcnt_d;   // frames left after current
  logic                x_q, x_d;
  logic                xv_q, xv_d;
  logic                fs_q, fs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                frame_end;

  // Next-state and registered-output computation; outputs are prepared one
  // cycle ahead so they leave the block straight from flops.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    sreg_d    = sreg_q;
    bcnt_d    = bcnt_q;
    fcnt_d    = fcnt_q;
    x_d       = 1'b0;
    xv_d      = 1'b0;
    fs_d      = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pat_d   = in_data;
          sreg_d  = in_data;
          bcnt_d  = LAST_BIT;
          fcnt_d  = in_reps;
          state_d = SHIFT;
          x_d     = in_data[DATA_W-1];
          xv_d    = 1'b1;
          fs_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      SHIFT: begin
        if (bcnt_q != '0) begin
          bcnt_d = bcnt_q - 1'b1;
          sreg_d = sreg_q << 1;
          x_d    = sreg_d[DATA_W-1];
          xv_d   = 1'b1;
          busy_d = 1'b1;
        end else begin
`ifdef SEQ_TX_GAP_EN
          state_d = GAP;
          busy_d  = 1'b1;
`else
          frame_end = 1'b1;
`endif
        end
      end
`ifdef SEQ_TX_GAP_EN
      GAP: begin
        frame_end = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // A frame has been fully sent: either start the next repeat with no
    // idle cycle or finish the transaction.
    if (frame_end) begin
      if (fcnt_q != '0) begin
        fcnt_d  = fcnt_q - 1'b1;
        sreg_d  = pat_q;
        bcnt_d  = LAST_BIT;
        state_d = SHIFT;
        x_d     = pat_q[DATA_W-1];
        xv_d    = 1'b1;
        fs_d    = 1'b1;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State and output registers; an asserted reset aborts any frame at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      fcnt_q  <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      fcnt_q  <= fcnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      fs_q    <= fs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign x           = x_q;
  assign x_valid     = xv_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_pattern_tx
// Description : Self-checking bench for seq_pattern_tx. A transaction-level
//               model predicts every bit/done event with its cycle number;
//               a monitor compares DUT outputs against that queue.
// Options     : SEQ_TX_GAP_EN - expect one gap cycle after every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;
  import seq_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int RW = REPS_W_DEF;
`ifdef SEQ_TX_GAP_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic [RW-1:0] in_reps = '0;
  logic          in_ready, x, x_valid, frame_start, busy, done;

  seq_pattern_tx #(.DATA_W(DW), .REPS_W(RW)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_reps     (in_reps),
    .x           (x),
    .x_valid     (x_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit is_done;
    bit x;
    bit fs;
  } exp_t;

  exp_t expq[$];
  int   hs_cyc   = -1;
  int   done_cyc = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   fs_seen  = 0;

  function automatic bit busy_exp();
    return (cyc > hs_cyc) && (cyc < done_cyc);
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Transaction model: F frames of DW bits, MSB first, starting the cycle
  // after the handshake, G idle cycles after each frame, then done.
  function automatic void model_push(input logic [DW-1:0] d, input logic [RW-1:0] r, input int n);
    exp_t e;
    int   f_tot = int'(r) + 1;
    hs_cyc = n;
    for (int f = 0; f < f_tot; f++) begin
      for (int i = 0; i < DW; i++) begin
        e.cyc     = n + 1 + f * (DW + G) + i;
        e.is_done = 1'b0;
        e.x       = d[DW-1-i];
        e.fs      = (i == 0);
        expq.push_back(e);
      end
    end
    done_cyc  = n + f_tot * (DW + G) + 1;
    e.cyc     = done_cyc;
    e.is_done = 1'b1;
    e.x       = 1'b0;
    e.fs      = 1'b0;
    expq.push_back(e);
  endfunction

  // Monitor: sample mid-cycle, check status every cycle, pop on each event.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   b;
    if (reset) begin
      b = busy_exp();
      check("busy", int'(busy), int'(b));
      check("in_ready", int'(in_ready), int'(!b));
      if (!x_valid) check("x_when_invalid", int'(x), 0);
      if (frame_start) fs_seen++;
      if (x_valid || done || frame_start) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: x_valid=%0d done=%0d frame_start=%0d with nothing expected (cycle %0d)",
                   x_valid, done, frame_start, cyc);
        end else begin
          e = expq.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("done", int'(done), int'(e.is_done));
          check("x_valid", int'(x_valid), int'(!e.is_done));
          if (!e.is_done) check("x", int'(x), int'(e.x));
          check("frame_start", int'(frame_start), int'(e.fs && !e.is_done));
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) next_cycle();
  endtask

  // Offer a transaction; while the model says the block is busy, throw
  // random in_valid pulses and data at it, which must be ignored.
  task automatic offer(input logic [DW-1:0] d, input logic [RW-1:0] r);
    int guard = 0;
    while (busy_exp()) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom);
      in_reps  = RW'($urandom);
      next_cycle();
      guard++;
      if (guard > 5000) begin
        $display("FAIL offer_timeout: waited %0d cycles, required at most 5000", guard);
        $fatal(1, "offer timeout");
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    in_reps  = r;
    model_push(d, r, cyc);
    next_cycle();
    in_valid = 1'b0;
    in_data  = DW'($urandom);
    in_reps  = RW'($urandom);
  endtask

  task automatic wait_done();
    int guard = 0;
    while (cyc <= done_cyc && guard < 5000) begin
      next_cycle();
      guard++;
    end
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"}, int'(x), 0);
    check({tag, "_x_valid"}, int'(x_valid), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int fs_base;
    reset = 1'b0;
    repeat (2) next_cycle();
    check_reset_outputs("reset_state");
    reset = 1'b1;
    idle(2);

    // Basic frame, repeated frames, then back-to-back in the done cycle.
    offer(PATTERN_1011, 4'd0);
    offer(PATTERN_1011, 4'd2);
    offer(4'b0110, 4'd0);
    wait_done();
    idle(2);

    // Reset asserted after the 2nd bit of a frame.
    offer(PATTERN_1011, 4'd0);
    next_cycle();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    expq.delete();
    done_cyc = cyc;
    next_cycle();
    reset = 1'b1;
    idle(2);
    offer(PATTERN_1011, 4'd0);
    wait_done();

    // Maximum repeat count.
    fs_base = fs_seen;
    offer(4'b1001, '1);
    wait_done();
    check("max_reps_frames", fs_seen - fs_base, 1 << RW);

    // Randomized transactions.
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      offer(DW'($urandom), RW'($urandom_range(0, 3)));
    end
    wait_done();
    idle(2);
    check("queue_empty", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: accepts a parallel bit pattern and a repeat count over a valid/ready handshake, then drives it MSB-first, one bit per clock, onto a single serial line. It is the stimulus-side counterpart of our serial sequence detectors, such as the 1011 Mealy detector. It sits between a control/register interface and the serial `x` input of a detector.

## Interface
- `DATA_W`, default 4: pattern width in bits; must be ≥ 2.
- `REPS_W`, default 4: width of the repeat-count field.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  pattern/count offered.
- `in_ready`  out  1  block can accept; equals (state == IDLE).
- `in_data`  in  DATA_W  pattern; bit DATA_W-1 is sent first.
- `in_reps`  in  REPS_W  number of extra frames; total frames = in_reps + 1.
- `x`  out  1  serial bit; registered.
- `x_valid`  out  1  `x` carries a pattern bit this cycle; registered.
- `frame_start`  out  1  high with the first bit of every frame; registered.
- `busy`  out  1  transaction in progress (SHIFT or GAP); registered.
- `done`  out  1  one-cycle pulse after the final bit of the transaction; registered.

## Operation
- States: IDLE, SHIFT, GAP. GAP is present only with the macro.
- IDLE behaviour:
  - `in_ready`=1.
  - On `in_valid`&`in_ready`, capture `in_data` into the shift register and `in_reps` into the frame counter.
  - Load the bit counter with DATA_W-1, then go to SHIFT.
- SHIFT behaviour:
  - Each cycle, drive `x` from the current MSB with `x_valid`=1 and shift left by one.
  - The bit counter decrements each cycle.
- End of frame (bit counter = 0):
  - If the frame counter ≠ 0: decrement it, reload the shift register from the captured pattern and the bit counter with DATA_W-1. Next frame follows with no idle cycle; go to GAP if the macro is defined.
  - If the frame counter = 0: go to IDLE (via GAP if the macro is defined) and pulse `done`.
- Outputs outside SHIFT: `x`=0, `x_valid`=0, `frame_start`=0.
- `in_valid` while not in IDLE is ignored. `in_data` and `in_reps` are sampled only at the handshake; later changes have no effect on the transaction.
- Counter widths:
  - Bit counter: $clog2(DATA_W) bits.
  - Frame counter: REPS_W bits. `in_reps` = all-ones gives 2^REPS_W frames, with no wrap.
- Reset values: `x`=0, `x_valid`=0, `frame_start`=0, `busy`=0, `done`=0, state IDLE, so `in_ready`=1.
- Reset asserted mid-frame aborts immediately. No `done` pulse is produced, and the remainder of the pattern is discarded.

## Timing
- Handshake in cycle N → first bit (MSB) on `x`, with `x_valid`=1 and `frame_start`=1, in cycle N+1.
- Without the macro:
  - Bits occupy cycles N+1 … N+F·DATA_W, where F = in_reps+1.
  - `done`=1 and `in_ready`=1 in cycle N+F·DATA_W+1.
  - A new handshake in that cycle is accepted; its first bit appears the next cycle.
  - `busy`=1 exactly in the bit cycles.
- With the macro:
  - One GAP cycle follows every frame, including the last. In it `x`=0 and `x_valid`=0.
  - `done` pulses in the cycle after the final GAP.
  - `busy` stays high through the GAP cycles.
- `done` and `frame_start` are single-cycle pulses and never coincide with each other.

## Configuration
- `SEQ_TX_GAP_EN`:
  - Defined: the GAP state is compiled in, giving one idle, invalid cycle after each frame. This guarantees a detector sees frame boundaries, so overlapping matches across frames are suppressed only where the detector resets on `x_valid`.
  - Undefined: frames are strictly back-to-back and the GAP state does not exist.

## Structure
- Shared package `seq_pkg`:
  - state enum (IDLE, SHIFT, GAP);
  - default DATA_W and REPS_W constants;
  - the 1011 reference pattern constant used by the detectors and benches.
- Single module; no sub-module is warranted. Shift register, bit counter and frame counter are small enough to live inline.

## Test plan
- Basic frame: DATA_W=4, `in_data`=4'b1011, `in_reps`=0, handshake at cycle 0.
  - `x`=1,0,1,1 in cycles 1–4, with `x_valid`=1 and `frame_start` in cycle 1.
  - `done`=1 in cycle 5. A 1011 detector fed this stream flags a match on cycle 4.
- Repeated frames: `in_data`=4'b1011, `in_reps`=2.
  - Stream is 101110111011 over cycles 1–12, with `frame_start` at cycles 1, 5 and 9.
  - `done` at cycle 13.
- Back-to-back transactions: second handshake (4'b0110, reps 0) in the `done` cycle of the first.
  - Bits 0,1,1,0 start the next cycle, with no extra idle.
  - `in_valid` pulses while `busy` leave state and outputs unchanged.
- Reset mid-frame: assert `reset` after the 2nd bit of 4'b1011.
  - All outputs are 0 and `in_ready`=1 asynchronously.
  - No `done` pulse; the next transaction starts cleanly from its MSB.
- Maximum repeats: `in_reps`=4'hF.
  - Exactly 16 frames, with `frame_start` counted 16 times.
  - `done` after 64 bit cycles.
- `SEQ_TX_GAP_EN` build: 4'b1011, `in_reps`=1.
  - Bits in cycles 1–4 and 6–9.
  - `x_valid`=0 in cycles 5 and 10; `done` in cycle 11.
